// File: rtl/alu_nbit_seq.sv
// rtl/alu_nbit_seq.sv - N-bit sequential ALU with valid/ready handshake and registered result/flags.
// Optional ALU_MUL_EN adds the multi-cycle shift-add MUL; without it sel=111 is single-cycle NOT a.
module alu_nbit_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             busy
);
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c, alu_v;
  logic             accept, consume;

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign busy     = (state_q == S_MUL);
`else
  assign in_ready = !out_valid_q || out_ready;
  assign busy     = 1'b0;
`endif

  assign accept    = in_valid && in_ready;
  assign consume   = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    alu_y = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (sel)
      OP_AND: alu_y = a & b;
      OP_OR:  alu_y = a | b;
      OP_XOR: alu_y = a ^ b;
      OP_ADD: begin
        alu_y = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // carry is the inverted borrow
        alu_y = diff[WIDTH-1:0];
        alu_c = ~diff[WIDTH];
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: alu_y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SHL: alu_y = a << b[SHW-1:0];
      OP_MUL: begin
`ifdef ALU_MUL_EN
        alu_y = '0;
`else
        alu_y = ~a;
`endif
      end
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    y_d         = y_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
`ifdef ALU_MUL_EN
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`endif
    if (consume) out_valid_d = 1'b0;
    if (accept) begin
`ifdef ALU_MUL_EN
      if (sel == OP_MUL) begin
        state_d  = S_MUL;
        mcand_d  = a;
        mplier_d = b;
        acc_d    = '0;
        cnt_d    = CW'(WIDTH);
      end else
`endif
      begin
        y_d         = alu_y;
        zero_d      = (alu_y == '0);
        carry_d     = alu_c;
        ovf_d       = alu_v;
        out_valid_d = 1'b1;
      end
    end
`ifdef ALU_MUL_EN
    // counter always runs to zero so MUL latency is fixed at WIDTH+1
    else if (state_q == S_MUL) begin
      if (cnt_q == '0) begin
        y_d         = acc_q;
        zero_d      = (acc_q == '0);
        carry_d     = 1'b0;
        ovf_d       = 1'b0;
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end else begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q         <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      y_q         <= y_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_MUL_EN
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_nbit_seq.sv
// tb/tb_alu_nbit_seq.sv - randomized and directed bench for alu_nbit_seq against a queue-based reference model.
// Expectations follow ALU_MUL_EN the same way the design does.
module tb_alu_nbit_seq;
  localparam int W = 8;

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, y;
  logic [2:0]   sel;
  logic         zero, carry, ovf, busy;

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [W-1:0] y;
    logic         z, c, v;
    int           ready_edge;
    bit           is_mul;
  } exp_t;

  exp_t exp_q[$];

  alu_nbit_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .carry(carry), .ovf(ovf), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t ref_op(input int ua, input int ub, input int op);
    exp_t e;
    int sa, sb, r;
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    e.c = 1'b0; e.v = 1'b0; e.is_mul = 1'b0; e.ready_edge = 0;
    case (op)
      0: r = ua & ub;
      1: r = ua | ub;
      2: r = ua ^ ub;
      3: begin r = ua + ub; e.c = (r > 255); e.v = (sa + sb > 127) || (sa + sb < -128); end
      4: begin r = ua - ub; e.c = (ua >= ub); e.v = (sa - sb > 127) || (sa - sb < -128); end
      5: r = (sa < sb) ? 1 : 0;
      6: r = ua << (ub % W);
`ifdef ALU_MUL_EN
      default: begin r = ua * ub; e.is_mul = 1'b1; end
`else
      default: r = 255 - ua;
`endif
    endcase
    e.y = W'(r & 255);
    e.z = (e.y == 0);
    return e;
  endfunction

  // one handshake cycle: drive at negedge, check against the model, update the model
  task automatic cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [2:0] is, input logic ordy);
    logic ov_m, busy_m, ir_m;
    exp_t h;
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; sel = is; out_ready = ordy;
    #1;
    ov_m   = (exp_q.size() > 0) && (edge_cnt >= exp_q[0].ready_edge);
    busy_m = (exp_q.size() > 0) && exp_q[$].is_mul && (edge_cnt < exp_q[$].ready_edge);
    ir_m   = !busy_m && (!ov_m || ordy);
    check_eq("out_valid", out_valid, ov_m);
    check_eq("busy", busy, busy_m);
    check_eq("in_ready", in_ready, ir_m);
    if (ov_m) begin
      h = exp_q[0];
      check_eq("y", y, h.y);
      check_eq("zero", zero, h.z);
      check_eq("carry", carry, h.c);
      check_eq("ovf", ovf, h.v);
      if (ordy) void'(exp_q.pop_front());
    end
    if (iv && ir_m) begin
      h = ref_op(int'(ia), int'(ib), int'(is));
      h.ready_edge = edge_cnt + 1 + (h.is_mul ? W + 1 : 0);
      exp_q.push_back(h);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check_eq("rst_y", y, 0);
    check_eq("rst_zero", zero, 0);
    check_eq("rst_carry", carry, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_ready", in_ready, 1);
  endtask

  task automatic dir_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [2:0] is, input logic [W-1:0] ey, input logic ez,
                        input logic ec, input logic ev);
    bit got = 0;
    cycle(1'b1, ia, ib, is, 1'b1);
    for (int i = 0; i < 20 && !got; i++) begin
      cycle(1'b0, ia, ib, is, 1'b1);
      if (out_valid) got = 1;
    end
    if (got) begin
      check_eq({tag, "_y"}, y, ey);
      check_eq({tag, "_zero"}, zero, ez);
      check_eq({tag, "_carry"}, carry, ec);
      check_eq({tag, "_ovf"}, ovf, ev);
    end else begin
      check_eq({tag, "_timeout"}, out_valid, 1);
    end
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] corner [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
    return W'($urandom);
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sel = '0;
    do_reset();

    dir_op("and", 8'hF0, 8'h3C, 3'b000, 8'h30, 0, 0, 0);
    dir_op("or",  8'hF0, 8'h3C, 3'b001, 8'hFC, 0, 0, 0);
    dir_op("xor", 8'hF0, 8'h3C, 3'b010, 8'hCC, 0, 0, 0);
    dir_op("add_ovf", 8'h7F, 8'h01, 3'b011, 8'h80, 0, 0, 1);
    dir_op("sub_borrow", 8'h00, 8'h01, 3'b100, 8'hFF, 0, 0, 0);
    dir_op("slt", 8'hFF, 8'h01, 3'b101, 8'h01, 0, 0, 0);
    dir_op("shl", 8'h81, 8'h03, 3'b110, 8'h08, 0, 0, 0);
    dir_op("sub_zero", 8'h55, 8'h55, 3'b100, 8'h00, 1, 1, 0);
`ifdef ALU_MUL_EN
    dir_op("mul", 8'h0D, 8'h0B, 3'b111, 8'h8F, 0, 0, 0);
    dir_op("mul_wrap", 8'h10, 8'h20, 3'b111, 8'h00, 1, 0, 0);
`else
    dir_op("not", 8'h0D, 8'h0B, 3'b111, 8'hF2, 0, 0, 0);
    dir_op("not2", 8'h10, 8'h20, 3'b111, 8'hEF, 0, 0, 0);
`endif

    // backpressure: hold an ADD result, then consume and accept on one edge
    cycle(1'b1, 8'h12, 8'h34, 3'b011, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'hAA, 8'h55, 3'b000, 1'b0);
    check_eq("bp_hold_y", y, 8'h46);
    check_eq("bp_in_ready", in_ready, 0);
    cycle(1'b1, 8'h05, 8'h06, 3'b100, 1'b1);
    cycle(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
    check_eq("b2b_valid", out_valid, 1);
    check_eq("b2b_y", y, 8'hFF);

    // reset during the fourth MUL cycle
    cycle(1'b1, 8'h0D, 8'h0B, 3'b111, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
    do_reset();
    dir_op("add_after_rst", 8'h02, 8'h03, 3'b011, 8'h05, 0, 0, 0);

    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 99) < 70, pick(), pick(), 3'($urandom), $urandom_range(0, 99) < 75);
    for (int i = 0; i < 30 && exp_q.size() > 0; i++)
      cycle(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
    check_eq("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_nbit_seq.md
Name: alu_nbit_seq

Overview:
- Parametrised N-bit successor to the team's 1-bit ALU. It keeps the a/b/sel/y operand style and widens the select to eight operations.
- Adds a valid/ready handshake on both sides, a registered result with flags, and a multi-cycle shift-add multiply.
- Sits between the operand-fetch stage and the writeback register in the datapath test harness.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).
- SHW, $clog2(WIDTH), number of low bits of b used as the shift amount.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and sel are valid this cycle.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sel  input  3  operation select.
- out_valid  output  1  y and flags hold a valid result.
- out_ready  input  1  consumer takes the result this cycle.
- y  output  WIDTH  registered result.
- zero  output  1  y == 0.
- carry  output  1  carry out of ADD; NOT borrow for SUB; 0 for all other ops.
- ovf  output  1  signed overflow for ADD/SUB; 0 for all other ops.
- busy  output  1  multiply in progress.

Behaviour:
- Reset (rst high at a clk edge):
  - y=0, zero=0, carry=0, ovf=0, out_valid=0, busy=0, state=IDLE.
  - Reset mid-multiply aborts the operation with no output produced.
  - in_ready is 1 on the first cycle after reset.
- Operation encoding:
  - 000 AND.
  - 001 OR.
  - 010 XOR.
  - 011 ADD: y = (a+b) mod 2^WIDTH.
  - 100 SUB: y = (a-b) mod 2^WIDTH.
  - 101 SLT: y = {0..0, signed(a) < signed(b)}.
  - 110 SHL: y = a << b[SHW-1:0]; zero fill.
  - 111 MUL: y = low WIDTH bits of unsigned a*b.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - An input is accepted on an edge where in_valid && in_ready.
  - A result is consumed on an edge where out_valid && out_ready.
  - While out_valid=1 and out_ready=0, y and all flags hold stable.
  - Simultaneous consume and accept on one edge is legal: the new result replaces the old one and out_valid stays 1. This gives back-to-back throughput of 1 op/cycle for single-cycle ops.
- Single-cycle ops (000-110): accepted at edge N; y/flags valid and out_valid=1 after edge N (latency 1).
- State machine IDLE / MUL:
  - IDLE --accept with sel=111--> MUL.
    - a is loaded into the multiplicand register, b into the multiplier register, the accumulator is cleared, and the counter is set to WIDTH.
    - busy=1, in_ready=0.
  - Each MUL cycle:
    - If multiplier[0]=1, add the multiplicand to the accumulator.
    - Shift the multiplicand left 1 and the multiplier right 1.
    - Decrement the counter.
  - MUL --counter reaches 0--> IDLE.
    - The accumulator is written to y and out_valid=1 on that edge.
    - carry=0, ovf=0, zero is updated.
  - MUL latency: exactly WIDTH+1 edges from the accept edge to out_valid rising.
  - Early termination: when the multiplier becomes 0, the block still counts to WIDTH, so latency is fixed.
  - MUL cannot start while out_valid=1 and out_ready=0; in_ready gates this.
- Flags:
  - zero is computed from the registered y value being written.
  - ADD: ovf = (a[MSB]==b[MSB]) && (y[MSB]!=a[MSB]).
  - SUB: ovf = (a[MSB]!=b[MSB]) && (y[MSB]!=a[MSB]).
- Shift amount: b[SHW-1:0] only; when WIDTH is not a power of two, amounts >= WIDTH give y=0.
- in_valid while in_ready=0 is ignored; no operands are latched and the source must hold them.

Optional Feature:
- ALU_MUL_EN defined:
  - MUL state and datapath are present as described.
  - busy reflects the MUL state.
- ALU_MUL_EN undefined:
  - No MUL state or registers; busy is tied to 0.
  - sel=111 executes single-cycle NOT a (y = ~a, carry=0, ovf=0, latency 1).

Test Plan:
- WIDTH=8, out_ready=1. Apply a=8'hF0, b=8'h3C across sel 000..010 -> y = 30, FC, CC, each 1 cycle after accept.
- ADD a=8'h7F, b=8'h01 -> y=80, ovf=1, carry=0. SUB a=8'h00, b=8'h01 -> y=FF, carry=0, ovf=0.
- SLT a=8'hFF, b=8'h01 -> y=01. SHL a=8'h81, b=8'h03 -> y=08. SUB a=b=8'h55 -> y=00, zero=1, carry=1.
- MUL (ALU_MUL_EN) a=8'h0D, b=8'h0B:
  - Result: out_valid rises exactly 9 edges after accept, y=8'h8F.
  - During MUL, busy=1 and in_ready=0.
  - Follow with MUL a=8'h10, b=8'h20 -> y=8'h00, zero=1.
- Backpressure:
  - Hold out_ready=0 after an ADD -> y/flags stable and in_ready=0 for 5 cycles.
  - Raise out_ready with a new in_valid on the same cycle -> new result on the next edge, out_valid stays 1.
- Assert rst during cycle 4 of a MUL -> next cycle y=0, out_valid=0, busy=0, in_ready=1. A subsequent ADD 2+3 -> y=05.
